memory_port_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the processor's instruction-fetch port, its load/store data port and an external program-loader port. Sits between the pipelined processor and the unified memory. Grants one access at a time and returns read data with a fixed latency. Drives a stall output that the processor uses to freeze fetch/memory stages while a request waits.

---
 rtl/memory_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the loader, instruction-fetch
// and load/store ports; read data returns READ_LATENCY cycles after the grant.
module memory_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_mode,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic                  load_gnt,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);

  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    READ_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  owner_t               owner_q, owner_d;

  logic gnt_load, gnt_fetch, gnt_data;
  logic read_ret, grant_ok, read_gnt;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Grant selection, read tracking and starvation accounting
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    gnt_load  = 1'b0;
    gnt_fetch = 1'b0;
    gnt_data  = 1'b0;

    // A new grant may overlap the cycle in which the outstanding read returns
    read_ret = (state_q == READ_WAIT) && (lat_q == LAT_LAST);
    grant_ok = reset_n && ((state_q == IDLE) || read_ret);

    if (grant_ok) begin
      if (load_req) begin
        gnt_load = 1'b1;
      end else if (!load_mode) begin
        if (fetch_req && (starve_q == STARVE_MAX)) begin
          gnt_fetch = 1'b1;
        end else if (data_req) begin
          gnt_data = 1'b1;
        end else if (fetch_req) begin
          gnt_fetch = 1'b1;
        end
      end
    end

    read_gnt = gnt_fetch || (gnt_data && !data_we);

    if (read_gnt) begin
      state_d = READ_WAIT;
      lat_d   = LAT_LOAD;
      owner_d = gnt_fetch ? OWN_FETCH : OWN_DATA;
    end else if (read_ret) begin
      state_d = IDLE;
      lat_d   = '0;
      owner_d = OWN_NONE;
    end else if (state_q == READ_WAIT) begin
      lat_d = lat_q - LAT_LAST;
    end

    if (gnt_fetch || !fetch_req) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // RAM request mux from the granted port
  always_comb begin
    mem_en    = gnt_load || gnt_fetch || gnt_data;
    mem_we    = gnt_load || (gnt_data && data_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_load) begin
      mem_addr  = load_addr;
      mem_wdata = load_wdata;
    end else if (gnt_fetch) begin
      mem_addr  = fetch_addr;
    end else if (gnt_data) begin
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // Read return routed to the owner only in the return cycle
  always_comb begin
    fetch_rvalid = reset_n && read_ret && (owner_q == OWN_FETCH);
    data_rvalid  = reset_n && read_ret && (owner_q == OWN_DATA);
    fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    data_rdata   = data_rvalid ? mem_rdata : '0;
  end

  assign load_gnt  = gnt_load;
  assign fetch_gnt = gnt_fetch;
  assign data_gnt  = gnt_data;
  assign stall     = reset_n && ((fetch_req && !gnt_fetch) || (data_req && !gnt_data));

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter: two instances (READ_LATENCY 1 and 3)
// checked every cycle against a cycle-count based reference model.
module tb_memory_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned N_CYCLES = 1500;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned RL = (g == 0) ? 1 : 3;
    localparam int unsigned SL = (g == 0) ? 4 : 2;

    logic          reset_n = 1'b0;
    logic          load_mode = 1'b0, load_req = 1'b0, fetch_req = 1'b0;
    logic          data_req = 1'b0, data_we = 1'b0;
    logic [AW-1:0] load_addr = '0, fetch_addr = '0, data_addr = '0;
    logic [DW-1:0] load_wdata = '0, data_wdata = '0;
    logic          load_gnt, fetch_gnt, fetch_rvalid, data_gnt, data_rvalid;
    logic [DW-1:0] fetch_rdata, data_rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, stall;
    logic [AW-1:0] mem_addr;
    logic          done = 1'b0;

    memory_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
    ) dut (
      .clock(clock), .reset_n(reset_n), .load_mode(load_mode),
      .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
    );

    // 16-word RAM with a READ_LATENCY pipeline; returns junk when no read is in flight
    logic [DW-1:0] ram [16];
    logic [DW-1:0] pipe [4];
    logic          ram_ready = 1'b0;
    always @(posedge clock) begin
      if (!ram_ready) begin
        for (int i = 0; i < 16; i++) ram[i] <= 32'h100 + DW'(4 * i);
        ram_ready <= 1'b1;
      end else if (mem_en && mem_we) begin
        ram[mem_addr[5:2]] <= mem_wdata;
      end
      pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[5:2]] : DW'($urandom);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RL-1];

    // Reference model: a pending read is just "owner, data, cycle it returns"
    logic [DW-1:0] shadow [16];
    bit            pv, pown;
    int unsigned   pret, cyc, starve;
    logic [DW-1:0] pdata;
    bit            prev_lg, prev_fg, prev_dg;
    string         p;

    task automatic drive();
      int unsigned mode;
      mode = (cyc / 200) % 3;
      load_mode = (mode == 2) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
      if (load_req && !prev_lg) begin
        if ($urandom_range(0, 15) == 0) load_req = 1'b0;
      end else begin
        load_req   = (mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
        load_addr  = AW'($urandom);
        load_wdata = DW'($urandom);
      end
      if (fetch_req && !prev_fg) begin
        if ($urandom_range(0, 15) == 0) fetch_req = 1'b0;
      end else begin
        fetch_req  = ($urandom_range(0, 3) != 0);
        fetch_addr = AW'($urandom);
      end
      if (data_req && !prev_dg) begin
        if ($urandom_range(0, 15) == 0 && mode != 1) data_req = 1'b0;
      end else begin
        data_req   = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        data_we    = (mode == 1) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
        data_addr  = AW'($urandom);
        data_wdata = DW'($urandom);
      end
    endtask

    task automatic check_quiet();
      check({p, "rst.load_gnt"}, 64'(load_gnt), 64'd0);
      check({p, "rst.fetch_gnt"}, 64'(fetch_gnt), 64'd0);
      check({p, "rst.data_gnt"}, 64'(data_gnt), 64'd0);
      check({p, "rst.fetch_rvalid"}, 64'(fetch_rvalid), 64'd0);
      check({p, "rst.data_rvalid"}, 64'(data_rvalid), 64'd0);
      check({p, "rst.fetch_rdata"}, 64'(fetch_rdata), 64'd0);
      check({p, "rst.data_rdata"}, 64'(data_rdata), 64'd0);
      check({p, "rst.mem_en"}, 64'(mem_en), 64'd0);
      check({p, "rst.mem_we"}, 64'(mem_we), 64'd0);
      check({p, "rst.mem_addr"}, 64'(mem_addr), 64'd0);
      check({p, "rst.mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({p, "rst.stall"}, 64'(stall), 64'd0);
    endtask

    initial begin : stim
      bit            ret, can, el, ef, ed, ewe;
      logic [AW-1:0] eaddr, raddr;
      logic [DW-1:0] ewdata;
      p = $sformatf("u%0d.", g);
      for (int i = 0; i < 16; i++) shadow[i] = 32'h100 + DW'(4 * i);
      pv = 0; pown = 0; pret = 0; cyc = 0; starve = 0; pdata = '0;
      prev_lg = 0; prev_fg = 0; prev_dg = 0;

      repeat (3) begin
        @(negedge clock);
        drive();
        #1 check_quiet();
      end

      for (int n = 0; n < int'(N_CYCLES); n++) begin
        @(negedge clock);
        if (n > 0) drive();
        if (n == 0) reset_n = 1'b1;
        // Asynchronous reset while a read is in flight drops the read
        if (pv && $urandom_range(0, 24) == 0) begin
          reset_n = 1'b0;
          #1 check_quiet();
          pv = 0; starve = 0;
          prev_lg = 0; prev_fg = 0; prev_dg = 0;
          @(negedge clock);
          reset_n = 1'b1;
          drive();
        end
        #1;
        ret = pv && (cyc == pret);
        can = !pv || ret;
        el  = can && load_req;
        ef  = can && !el && !load_mode && fetch_req && ((starve == SL) || !data_req);
        ed  = can && !el && !load_mode && data_req && !ef;
        ewe = el || (ed && data_we);
        eaddr  = el ? load_addr : ef ? fetch_addr : ed ? data_addr : '0;
        ewdata = el ? load_wdata : (ed && data_we) ? data_wdata : '0;

        check({p, "load_gnt"}, 64'(load_gnt), 64'(el));
        check({p, "fetch_gnt"}, 64'(fetch_gnt), 64'(ef));
        check({p, "data_gnt"}, 64'(data_gnt), 64'(ed));
        check({p, "mem_en"}, 64'(mem_en), 64'(el || ef || ed));
        check({p, "mem_we"}, 64'(mem_we), 64'(ewe));
        check({p, "mem_addr"}, 64'(mem_addr), 64'(eaddr));
        if (ewe || !(el || ef || ed)) check({p, "mem_wdata"}, 64'(mem_wdata), 64'(ewdata));
        check({p, "fetch_rvalid"}, 64'(fetch_rvalid), 64'(ret && !pown));
        check({p, "fetch_rdata"}, 64'(fetch_rdata), (ret && !pown) ? 64'(pdata) : 64'd0);
        check({p, "data_rvalid"}, 64'(data_rvalid), 64'(ret && pown));
        check({p, "data_rdata"}, 64'(data_rdata), (ret && pown) ? 64'(pdata) : 64'd0);
        check({p, "stall"}, 64'(stall), 64'((fetch_req && !ef) || (data_req && !ed)));

        if (el) shadow[load_addr[5:2]] = load_wdata;
        if (ed && data_we) shadow[data_addr[5:2]] = data_wdata;
        if (ef || (ed && !data_we)) begin
          raddr = ef ? fetch_addr : data_addr;
          pv    = 1;
          pown  = ed;
          pret  = cyc + RL;
          pdata = shadow[raddr[5:2]];
        end else if (ret) begin
          pv = 0;
        end
        starve  = (ef || !fetch_req) ? 0 : ((starve < SL) ? starve + 1 : starve);
        prev_lg = el; prev_fg = ef; prev_dg = ed;
        cyc++;
      end
      done = 1'b1;
    end
  end

  initial begin : main
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock);
      if (u[0].done && u[1].done) break;
    end
    check("tb.completion", {62'd0, u[1].done, u[0].done}, 64'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
